ysyx_23060191_lsu_fsm: RTL and testbench

Parametrised multi-cycle load/store unit placed between EXU and the data-memory port, replacing the single-cycle DPI-backed LSU. Accepts one request at a time over a valid/ready handshake and drives an SRAM-style request/response bus. It aligns addresses to the bus word and generates byte strobes. It also sign- or zero-extends load data, and reports misaligned, illegal and timed-out accesses as error codes instead of touching memory.

---
 rtl/ysyx_23060191_lsu_fsm_pkg.sv | 32 +++
 rtl/ysyx_23060191_lsu_fsm_align.sv | 69 ++++++
 rtl/ysyx_23060191_lsu_fsm.sv | 155 +++++++++++++++
 tb/tb_ysyx_23060191_lsu_fsm.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060191_lsu_fsm_pkg.sv
// Shared definitions for the multi-cycle LSU: operation codes, response error codes
// and the FSM state encoding.
package ysyx_23060191_lsu_fsm_pkg;

   localparam int LSU_OPT_WIDTH = 4;

   // op = {unsigned, size[1:0], store}
   localparam logic [LSU_OPT_WIDTH-1:0] LSU_LB  = 4'b0000;
   localparam logic [LSU_OPT_WIDTH-1:0] LSU_LH  = 4'b0010;
   localparam logic [LSU_OPT_WIDTH-1:0] LSU_LW  = 4'b0100;
   localparam logic [LSU_OPT_WIDTH-1:0] LSU_LD  = 4'b0110;
   localparam logic [LSU_OPT_WIDTH-1:0] LSU_LBU = 4'b1000;
   localparam logic [LSU_OPT_WIDTH-1:0] LSU_LHU = 4'b1010;
   localparam logic [LSU_OPT_WIDTH-1:0] LSU_LWU = 4'b1100;
   localparam logic [LSU_OPT_WIDTH-1:0] LSU_SB  = 4'b0001;
   localparam logic [LSU_OPT_WIDTH-1:0] LSU_SH  = 4'b0011;
   localparam logic [LSU_OPT_WIDTH-1:0] LSU_SW  = 4'b0101;
   localparam logic [LSU_OPT_WIDTH-1:0] LSU_SD  = 4'b0111;

   localparam logic [1:0] LSU_ERR_OK       = 2'b00;
   localparam logic [1:0] LSU_ERR_MISALIGN = 2'b01;
   localparam logic [1:0] LSU_ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] LSU_ERR_ILLEGAL  = 2'b11;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2,
      LSU_RESP = 2'd3
   } lsu_state_e;

endpackage

// File: rtl/ysyx_23060191_lsu_fsm_align.sv
// Combinational lane logic: byte strobes, store-data shift, load extraction/extension
// and the illegal/misaligned classification of an op at a given lane offset.
module ysyx_23060191_lsu_align
   import ysyx_23060191_lsu_fsm_pkg::*;
#(
   parameter int XLEN = 32,
   localparam int NB    = XLEN / 8,
   localparam int OFF_W = $clog2(NB)
) (
   input  logic [LSU_OPT_WIDTH-1:0] op,
   input  logic [OFF_W-1:0]         off,
   input  logic [XLEN-1:0]          wdata,
   input  logic [XLEN-1:0]          rdata,
   output logic [NB-1:0]            wstrb,
   output logic [XLEN-1:0]          wdata_sh,
   output logic [XLEN-1:0]          rdata_ext,
   output logic                     illegal,
   output logic                     misaligned
);
   localparam int SHW = $clog2(XLEN);

   logic            is_store;
   logic            is_uns;
   logic [1:0]      size;
   logic [3:0]      nbytes;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] top_just;
   logic [SHW-1:0]  sh_amt;

   assign is_store = op[0];
   assign size     = op[2:1];
   assign is_uns   = op[3];
   assign nbytes   = 4'd1 << size;

   assign wdata_sh   = wdata << {off, 3'b000};
   assign shifted    = rdata >> {off, 3'b000};
   assign misaligned = |(off & OFF_W'(nbytes - 4'd1));

   for (genvar gi = 0; gi < NB; gi++) begin : g_strb
      assign wstrb[gi] = is_store && (gi >= int'(off)) && (gi < int'(off) + int'(nbytes));
   end

   // An unsigned doubleword load has no defined op, so it is rejected with the rest.
   always_comb begin
      illegal = 1'b0;
      if (is_store && is_uns)
         illegal = 1'b1;
      if (size == 2'b11 && (XLEN == 32 || is_uns))
         illegal = 1'b1;
      if (size == 2'b10 && is_uns && XLEN == 32)
         illegal = 1'b1;
   end

   // Move the access to the top of the word, then shift back arithmetically or logically.
   always_comb begin
      case (size)
         2'b00:   sh_amt = SHW'(XLEN - 8);
         2'b01:   sh_amt = SHW'(XLEN - 16);
         2'b10:   sh_amt = SHW'(XLEN - 32);
         default: sh_amt = '0;
      endcase
      top_just = shifted << sh_amt;
      if (is_uns)
         rdata_ext = top_just >> sh_amt;
      else
         rdata_ext = $unsigned($signed(top_just) >>> sh_amt);
   end

endmodule

// File: rtl/ysyx_23060191_lsu_fsm.sv
// Multi-cycle load/store unit: one request at a time from EXU, SRAM-style memory bus,
// formatted result or error code back to WBU.
module ysyx_23060191_lsu_fsm
   import ysyx_23060191_lsu_fsm_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [LSU_OPT_WIDTH-1:0] req_op,
   input  logic [ADDR_W-1:0]        req_addr,
   input  logic [XLEN-1:0]          req_wdata,
   output logic                     mem_req_valid,
   input  logic                     mem_req_ready,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [XLEN-1:0]          mem_wdata,
   output logic [XLEN/8-1:0]        mem_wstrb,
   input  logic                     mem_rsp_valid,
   input  logic [XLEN-1:0]          mem_rdata,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [XLEN-1:0]          rsp_data,
   output logic [1:0]               rsp_err
);
   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   lsu_state_e               state_reg, state_next;
   logic [LSU_OPT_WIDTH-1:0] op_reg, op_next;
   logic [ADDR_W-1:0]        addr_reg, addr_next;
   logic [XLEN-1:0]          wdata_reg, wdata_next;
   logic [CNT_W-1:0]         cnt_reg, cnt_next;
   logic [XLEN-1:0]          rsp_data_reg, rsp_data_next;
   logic [1:0]               rsp_err_reg, rsp_err_next;

   logic                     in_idle;
   logic [LSU_OPT_WIDTH-1:0] al_op;
   logic [OFF_W-1:0]         al_off;
   logic [NB-1:0]            al_wstrb;
   logic [XLEN-1:0]          al_wdata;
   logic [XLEN-1:0]          al_rdata_ext;
   logic                     al_illegal;
   logic                     al_misaligned;

   // In IDLE the aligner classifies the incoming request; afterwards it serves the latched one.
   assign in_idle = (state_reg == LSU_IDLE);
   assign al_op   = in_idle ? req_op : op_reg;
   assign al_off  = in_idle ? req_addr[OFF_W-1:0] : addr_reg[OFF_W-1:0];

   ysyx_23060191_lsu_align #(.XLEN(XLEN)) u_align (
      .op         (al_op),
      .off        (al_off),
      .wdata      (wdata_reg),
      .rdata      (mem_rdata),
      .wstrb      (al_wstrb),
      .wdata_sh   (al_wdata),
      .rdata_ext  (al_rdata_ext),
      .illegal    (al_illegal),
      .misaligned (al_misaligned)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg    <= LSU_IDLE;
         op_reg       <= '0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         cnt_reg      <= '0;
         rsp_data_reg <= '0;
         rsp_err_reg  <= LSU_ERR_OK;
      end else begin
         state_reg    <= state_next;
         op_reg       <= op_next;
         addr_reg     <= addr_next;
         wdata_reg    <= wdata_next;
         cnt_reg      <= cnt_next;
         rsp_data_reg <= rsp_data_next;
         rsp_err_reg  <= rsp_err_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      op_next       = op_reg;
      addr_next     = addr_reg;
      wdata_next    = wdata_reg;
      cnt_next      = cnt_reg;
      rsp_data_next = rsp_data_reg;
      rsp_err_next  = rsp_err_reg;
      case (state_reg)
         LSU_IDLE: begin
            if (req_valid) begin
               op_next       = req_op;
               addr_next     = req_addr;
               wdata_next    = req_wdata;
               cnt_next      = '0;
               rsp_data_next = '0;
               rsp_err_next  = LSU_ERR_OK;
               if (al_illegal) begin
                  rsp_err_next = LSU_ERR_ILLEGAL;
                  state_next   = LSU_RESP;
               end else if (al_misaligned) begin
                  rsp_err_next = LSU_ERR_MISALIGN;
                  state_next   = LSU_RESP;
               end else begin
                  state_next = LSU_REQ;
               end
            end
         end
         LSU_REQ: begin
            if (mem_req_ready) begin
               cnt_next   = '0;
               state_next = LSU_WAIT;
            end
         end
         LSU_WAIT: begin
            if (mem_rsp_valid) begin
               rsp_data_next = op_reg[0] ? '0 : al_rdata_ext;
               rsp_err_next  = LSU_ERR_OK;
               state_next    = LSU_RESP;
            end else if (TIMEOUT != 0 && cnt_reg == CNT_MAX) begin
               rsp_data_next = '0;
               rsp_err_next  = LSU_ERR_TIMEOUT;
               state_next    = LSU_RESP;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         LSU_RESP: begin
            if (rsp_ready)
               state_next = LSU_IDLE;
         end
         default: state_next = LSU_IDLE;
      endcase
   end

   // Bus outputs are forced to zero outside their owning state so reset and idle read as 0.
   assign req_ready     = rstn && in_idle;
   assign mem_req_valid = (state_reg == LSU_REQ);
   assign mem_we        = mem_req_valid && op_reg[0];
   assign mem_addr      = mem_req_valid ? {addr_reg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
   assign mem_wdata     = mem_req_valid ? al_wdata : '0;
   assign mem_wstrb     = mem_req_valid ? al_wstrb : '0;
   assign rsp_valid     = (state_reg == LSU_RESP);
   assign rsp_data      = rsp_valid ? rsp_data_reg : '0;
   assign rsp_err       = rsp_valid ? rsp_err_reg : LSU_ERR_OK;

endmodule

// File: tb/tb_ysyx_23060191_lsu_fsm.sv
// Directed bench: a 32-bit instance (TIMEOUT=4) driven from a vector table plus stall and
// timeout sequences, and a 64-bit instance for doubleword, lane and reset-in-WAIT cases.
module tb_ysyx_23060191_lsu_fsm;
   import ysyx_23060191_lsu_fsm_pkg::*;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic        a_req_valid, a_req_ready, a_mem_req_valid, a_mem_req_ready, a_mem_we;
   logic [3:0]  a_req_op, a_mem_wstrb;
   logic [31:0] a_req_addr, a_req_wdata, a_mem_addr, a_mem_wdata, a_mem_rdata, a_rsp_data;
   logic        a_mem_rsp_valid, a_rsp_valid, a_rsp_ready;
   logic [1:0]  a_rsp_err;

   logic        b_req_valid, b_req_ready, b_mem_req_valid, b_mem_req_ready, b_mem_we;
   logic [3:0]  b_req_op;
   logic [7:0]  b_mem_wstrb;
   logic [31:0] b_req_addr, b_mem_addr;
   logic [63:0] b_req_wdata, b_mem_wdata, b_mem_rdata, b_rsp_data;
   logic        b_mem_rsp_valid, b_rsp_valid, b_rsp_ready;
   logic [1:0]  b_rsp_err;

   ysyx_23060191_lsu_fsm #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
      .clk(clk), .rstn(rstn),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_op(a_req_op),
      .req_addr(a_req_addr), .req_wdata(a_req_wdata),
      .mem_req_valid(a_mem_req_valid), .mem_req_ready(a_mem_req_ready), .mem_we(a_mem_we),
      .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb),
      .mem_rsp_valid(a_mem_rsp_valid), .mem_rdata(a_mem_rdata),
      .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data), .rsp_err(a_rsp_err)
   );

   ysyx_23060191_lsu_fsm #(.XLEN(64), .ADDR_W(32), .TIMEOUT(255)) dut64 (
      .clk(clk), .rstn(rstn),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready), .mem_we(b_mem_we),
      .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb),
      .mem_rsp_valid(b_mem_rsp_valid), .mem_rdata(b_mem_rdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        exp_we;
      logic [31:0] exp_maddr;
      logic [3:0]  exp_strb;
      logic [31:0] exp_wdata;
      logic [1:0]  exp_err;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Zero-wait memory on the 32-bit instance; error vectors must skip the bus entirely.
   task automatic run_vec(input int idx, input vec_t v);
      logic [31:0] got_data;
      logic [1:0]  got_err;
      a_req_valid = 1'b1; a_req_op = v.op; a_req_addr = v.addr; a_req_wdata = v.wdata;
      chk($sformatf("v%0d_req_ready", idx), a_req_ready, 1);
      tick();
      a_req_valid = 1'b0;
      if (v.exp_err == LSU_ERR_MISALIGN || v.exp_err == LSU_ERR_ILLEGAL) begin
         chk($sformatf("v%0d_err_mem_req_valid", idx), a_mem_req_valid, 0);
      end else begin
         chk($sformatf("v%0d_mem_req_valid", idx), a_mem_req_valid, 1);
         chk($sformatf("v%0d_mem_we", idx), a_mem_we, v.exp_we);
         chk($sformatf("v%0d_mem_addr", idx), a_mem_addr, v.exp_maddr);
         chk($sformatf("v%0d_mem_wstrb", idx), a_mem_wstrb, v.exp_strb);
         chk($sformatf("v%0d_mem_wdata", idx), a_mem_wdata, v.exp_wdata);
         chk($sformatf("v%0d_req_ready_busy", idx), a_req_ready, 0);
         a_mem_req_ready = 1'b1;
         tick();
         a_mem_req_ready = 1'b0;
         chk($sformatf("v%0d_rsp_valid_wait", idx), a_rsp_valid, 0);
         a_mem_rsp_valid = 1'b1; a_mem_rdata = v.rdata;
         tick();
         a_mem_rsp_valid = 1'b0;
      end
      chk($sformatf("v%0d_rsp_valid", idx), a_rsp_valid, 1);
      chk($sformatf("v%0d_rsp_data", idx), a_rsp_data, v.exp_data);
      chk($sformatf("v%0d_rsp_err", idx), a_rsp_err, v.exp_err);
      got_data = a_rsp_data; got_err = a_rsp_err;
      a_rsp_ready = 1'b1;
      tick();
      a_rsp_ready = 1'b0;
      chk($sformatf("v%0d_rsp_valid_done", idx), a_rsp_valid, 0);
      chk($sformatf("v%0d_req_ready_done", idx), a_req_ready, 1);
      $display("vec %0d op=%b addr=%h wdata=%h -> data=%h err=%b", idx, v.op, v.addr, v.wdata, got_data, got_err);
   endtask

   task automatic b_txn(input string name, input logic [3:0] op, input logic [31:0] addr,
                        input logic [63:0] wdata, input logic [63:0] rdata,
                        input logic [31:0] e_maddr, input logic [7:0] e_strb,
                        input logic [63:0] e_wdata, input logic [63:0] e_data);
      b_req_valid = 1'b1; b_req_op = op; b_req_addr = addr; b_req_wdata = wdata;
      tick();
      b_req_valid = 1'b0;
      chk({name, "_mem_req_valid"}, b_mem_req_valid, 1);
      chk({name, "_mem_addr"}, b_mem_addr, e_maddr);
      chk({name, "_mem_wstrb"}, b_mem_wstrb, e_strb);
      chk({name, "_mem_wdata"}, b_mem_wdata, e_wdata);
      b_mem_req_ready = 1'b1;
      tick();
      b_mem_req_ready = 1'b0;
      b_mem_rsp_valid = 1'b1; b_mem_rdata = rdata;
      tick();
      b_mem_rsp_valid = 1'b0;
      chk({name, "_rsp_valid"}, b_rsp_valid, 1);
      chk({name, "_rsp_data"}, b_rsp_data, e_data);
      chk({name, "_rsp_err"}, b_rsp_err, LSU_ERR_OK);
      $display("x64 %s op=%b addr=%h -> data=%h err=%b", name, op, addr, b_rsp_data, b_rsp_err);
      b_rsp_ready = 1'b1;
      tick();
      b_rsp_ready = 1'b0;
   endtask

   initial begin
      int cnt;
      a_req_valid = 0; a_req_op = 0; a_req_addr = 0; a_req_wdata = 0;
      a_mem_req_ready = 0; a_mem_rsp_valid = 0; a_mem_rdata = 0; a_rsp_ready = 0;
      b_req_valid = 0; b_req_op = 0; b_req_addr = 0; b_req_wdata = 0;
      b_mem_req_ready = 0; b_mem_rsp_valid = 0; b_mem_rdata = 0; b_rsp_ready = 0;

      //          op      addr          wdata         rdata         we    maddr         strb     wdata         err    data
      vecs[0]  = '{LSU_SB,  32'h8000_0003, 32'h0000_00AB, 32'h0,        1'b1, 32'h8000_0000, 4'b1000, 32'hAB00_0000, 2'b00, 32'h0};
      vecs[1]  = '{LSU_LH,  32'h8000_0002, 32'h0,        32'h8001_1234, 1'b0, 32'h8000_0000, 4'b0000, 32'h0,        2'b00, 32'hFFFF_8001};
      vecs[2]  = '{LSU_LHU, 32'h8000_0002, 32'h0,        32'h8001_1234, 1'b0, 32'h8000_0000, 4'b0000, 32'h0,        2'b00, 32'h0000_8001};
      vecs[3]  = '{LSU_LW,  32'h8000_0002, 32'h0,        32'h0,        1'b0, 32'h0,        4'b0000, 32'h0,        2'b01, 32'h0};
      vecs[4]  = '{LSU_SW,  32'h1000_0004, 32'hDEAD_BEEF, 32'h0,        1'b1, 32'h1000_0004, 4'b1111, 32'hDEAD_BEEF, 2'b00, 32'h0};
      vecs[5]  = '{LSU_SH,  32'h0000_2001, 32'h0000_1234, 32'h0,        1'b0, 32'h0,        4'b0000, 32'h0,        2'b01, 32'h0};
      vecs[6]  = '{LSU_LB,  32'h0000_3001, 32'h0,        32'h1234_80FF, 1'b0, 32'h0000_3000, 4'b0000, 32'h0,        2'b00, 32'hFFFF_FF80};
      vecs[7]  = '{LSU_LBU, 32'h0000_3003, 32'h0,        32'h7F00_0000, 1'b0, 32'h0000_3000, 4'b0000, 32'h0,        2'b00, 32'h0000_007F};
      vecs[8]  = '{LSU_SH,  32'h0000_2002, 32'h1234_5678, 32'h0,        1'b1, 32'h0000_2000, 4'b1100, 32'h5678_0000, 2'b00, 32'h0};
      vecs[9]  = '{LSU_LD,  32'h0000_0000, 32'h0,        32'h0,        1'b0, 32'h0,        4'b0000, 32'h0,        2'b11, 32'h0};
      vecs[10] = '{LSU_LWU, 32'h0000_0000, 32'h0,        32'h0,        1'b0, 32'h0,        4'b0000, 32'h0,        2'b11, 32'h0};
      vecs[11] = '{4'b1001, 32'h0000_0000, 32'h0,        32'h0,        1'b0, 32'h0,        4'b0000, 32'h0,        2'b11, 32'h0};
      vecs[12] = '{LSU_LW,  32'h0000_0008, 32'h0,        32'hCAFE_F00D, 1'b0, 32'h0000_0008, 4'b0000, 32'h0,        2'b00, 32'hCAFE_F00D};
      vecs[13] = '{LSU_LB,  32'h0000_0000, 32'h0,        32'h0000_007F, 1'b0, 32'h0,        4'b0000, 32'h0,        2'b00, 32'h0000_007F};

      #1;
      chk("rst_req_ready", a_req_ready, 0);
      chk("rst_mem_req_valid", a_mem_req_valid, 0);
      chk("rst_rsp_valid", a_rsp_valid, 0);
      chk("rst_mem_addr", a_mem_addr, 0);
      chk("rst_mem_wstrb", a_mem_wstrb, 0);
      chk("rst_rsp_err", a_rsp_err, 0);
      tick(); tick();
      rstn = 1'b1;
      #1;
      chk("post_rst_req_ready32", a_req_ready, 1);
      chk("post_rst_req_ready64", b_req_ready, 1);
      $display("reset released");

      for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

      // Memory back-pressure for 5 cycles, then WBU back-pressure for 3.
      a_req_valid = 1'b1; a_req_op = LSU_LW; a_req_addr = 32'h0000_0100; a_req_wdata = 32'h0;
      tick();
      a_req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("stall_mem_req_valid", a_mem_req_valid, 1);
         chk("stall_mem_addr", a_mem_addr, 32'h0000_0100);
         chk("stall_mem_we", a_mem_we, 0);
         chk("stall_mem_wstrb", a_mem_wstrb, 0);
         chk("stall_req_ready", a_req_ready, 0);
         tick();
      end
      a_mem_req_ready = 1'b1;
      tick();
      a_mem_req_ready = 1'b0;
      a_mem_rsp_valid = 1'b1; a_mem_rdata = 32'h1122_3344;
      tick();
      a_mem_rsp_valid = 1'b0; a_mem_rdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         chk("hold_rsp_valid", a_rsp_valid, 1);
         chk("hold_rsp_data", a_rsp_data, 32'h1122_3344);
         chk("hold_rsp_err", a_rsp_err, 0);
         chk("hold_req_ready", a_req_ready, 0);
         tick();
      end
      a_rsp_ready = 1'b1;
      tick();
      a_rsp_ready = 1'b0;
      chk("stall_done_rsp_valid", a_rsp_valid, 0);
      chk("stall_done_req_ready", a_req_ready, 1);
      $display("stall LW addr=00000100 -> data=11223344 held");

      // Memory never answers: timeout, then a stray response in IDLE.
      a_req_valid = 1'b1; a_req_op = LSU_LW; a_req_addr = 32'h0000_0040;
      tick();
      a_req_valid = 1'b0;
      chk("to_mem_req_valid", a_mem_req_valid, 1);
      a_mem_req_ready = 1'b1;
      tick();
      a_mem_req_ready = 1'b0;
      cnt = 0;
      while (!a_rsp_valid && cnt < 20) begin
         tick();
         cnt++;
      end
      chk("to_rsp_valid", a_rsp_valid, 1);
      chk("to_latency_in_range", (cnt == 4 || cnt == 5), 1);
      chk("to_rsp_err", a_rsp_err, LSU_ERR_TIMEOUT);
      chk("to_rsp_data", a_rsp_data, 0);
      a_rsp_ready = 1'b1;
      tick();
      a_rsp_ready = 1'b0;
      a_mem_rsp_valid = 1'b1; a_mem_rdata = 32'h5555_AAAA;
      tick();
      a_mem_rsp_valid = 1'b0;
      chk("late_rsp_valid", a_rsp_valid, 0);
      chk("late_req_ready", a_req_ready, 1);
      chk("late_mem_req_valid", a_mem_req_valid, 0);
      tick();
      chk("late_rsp_valid2", a_rsp_valid, 0);
      $display("timeout LW addr=00000040 -> err=10 after %0d wait cycles", cnt);

      b_txn("ld", LSU_LD, 32'h8, 64'h0, 64'h0123_4567_89AB_CDEF, 32'h8, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF);
      b_txn("sw", LSU_SW, 32'h4, 64'hAABB_CCDD, 64'h0, 32'h0, 8'hF0, 64'hAABB_CCDD_0000_0000, 64'h0);
      b_txn("lw", LSU_LW, 32'hC, 64'h0, 64'h8765_4321_0000_0000, 32'h8, 8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321);
      b_txn("lwu", LSU_LWU, 32'hC, 64'h0, 64'h8765_4321_0000_0000, 32'h8, 8'h00, 64'h0, 64'h0000_0000_8765_4321);

      // Reset asserted while the 64-bit instance sits in WAIT.
      b_req_valid = 1'b1; b_req_op = LSU_LD; b_req_addr = 32'h10;
      tick();
      b_req_valid = 1'b0;
      b_mem_req_ready = 1'b1;
      tick();
      b_mem_req_ready = 1'b0;
      rstn = 1'b0;
      #1;
      chk("rw_req_ready", b_req_ready, 0);
      chk("rw_mem_req_valid", b_mem_req_valid, 0);
      chk("rw_mem_addr", b_mem_addr, 0);
      chk("rw_rsp_valid", b_rsp_valid, 0);
      chk("rw_rsp_data", b_rsp_data, 0);
      chk("rw_rsp_err", b_rsp_err, 0);
      tick();
      rstn = 1'b1;
      b_mem_rsp_valid = 1'b1; b_mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      tick();
      b_mem_rsp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("rw_after_rsp_valid", b_rsp_valid, 0);
         chk("rw_after_req_ready", b_req_ready, 1);
         tick();
      end
      $display("reset in WAIT: outputs cleared, no response");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
